// File: rtl/piso_out_ctrl.sv
// piso_out_ctrl
//   Sequencer for the output-side PISO buffer (WIDTH x NUM_TAPS). Accepts one
//   parallel result frame via IN_VALID/IN_READY, loads it into the PISO, then
//   streams the words downstream one per OUT_VALID/OUT_READY handshake with a
//   tap index and last flag. Counts completed frames.
//
// Ports
//   CLKEXT     in   system clock, rising edge
//   CLR_N      in   synchronous active-low reset
//   IN_VALID   in   parallel frame present on the PISO DATA_IN bus
//   IN_READY   out  controller can accept a frame
//   ABORT      in   synchronous frame abort, beats every input except CLR_N
//   OUT_READY  in   downstream accepts the current word
//   OUT_VALID  out  PISO DATA_OUT holds a valid word
//   OUT_LAST   out  current word is tap NUM_TAPS-1
//   OUT_IDX    out  index of the current word (0 first)
//   PISO_EN    out  PISO enable (load when SHIFT=0, advance when SHIFT=1)
//   PISO_SHIFT out  PISO shift select
//   PISO_CLR   out  PISO clear, active high
//   DONE       out  one-cycle pulse when a frame completes
//   FRAME_CNT  out  completed-frame counter, wraps
module piso_out_ctrl #(
    parameter int NUM_TAPS = 4,
    parameter int IDX_W    = 2,
    parameter int FCNT_W   = 16
) (
    input  logic              CLKEXT,
    input  logic              CLR_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              ABORT,
    input  logic              OUT_READY,
    output logic              OUT_VALID,
    output logic              OUT_LAST,
    output logic [IDX_W-1:0]  OUT_IDX,
    output logic              PISO_EN,
    output logic              PISO_SHIFT,
    output logic              PISO_CLR,
    output logic              DONE,
    output logic [FCNT_W-1:0] FRAME_CNT
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE_ST} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             live;
    logic             at_last;

    // Reset and abort both kill every handshake and control for the cycle.
    assign live    = CLR_N & ~ABORT;
    assign at_last = (idx == LAST_IDX);

    always_ff @(posedge CLKEXT) begin
        if (!CLR_N) begin
            state     <= IDLE;
            idx       <= '0;
            FRAME_CNT <= '0;
        end else if (ABORT) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // IN_READY is high whenever we get here without ABORT.
                    if (IN_VALID) state <= LOAD;
                end
                LOAD: begin
                    idx   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (OUT_READY) begin
                        if (at_last) state <= DONE_ST;
                        else         idx   <= idx + 1'b1;
                    end
                end
                DONE_ST: begin
                    FRAME_CNT <= FRAME_CNT + 1'b1;
                    idx       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control decode. Only PISO_EN/PISO_SHIFT look at OUT_READY, so there is
    // no combinational path from OUT_READY to OUT_VALID or IN_READY.
    always_comb begin
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        OUT_LAST   = 1'b0;
        OUT_IDX    = '0;
        PISO_EN    = 1'b0;
        PISO_SHIFT = 1'b0;
        DONE       = 1'b0;
        PISO_CLR   = ~live;
        if (live) begin
            case (state)
                IDLE:   IN_READY = 1'b1;
                LOAD:   PISO_EN  = 1'b1;
                STREAM: begin
                    OUT_VALID = 1'b1;
                    OUT_IDX   = idx;
                    OUT_LAST  = at_last;
                    // Advance the PISO in the same cycle the word is taken;
                    // the last word needs no shift.
                    PISO_EN    = OUT_READY & ~at_last;
                    PISO_SHIFT = OUT_READY & ~at_last;
                end
                DONE_ST: begin
                    DONE     = 1'b1;
                    PISO_CLR = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_out_ctrl.sv
// tb_piso_out_ctrl
//   Randomized and directed stimulus for piso_out_ctrl, checked every cycle
//   against a frame-position model and a behavioural PISO buffer driven by the
//   DUT's own controls. A second instance with FCNT_W=2 shares the inputs to
//   exercise counter wrap.
module tb_piso_out_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;

    logic          in_ready, out_valid, out_last, piso_en, piso_shift, piso_clr, done;
    logic [IW-1:0] out_idx;
    logic [15:0]   frame_cnt;

    logic          w_in_ready, w_out_valid, w_out_last, w_piso_en, w_piso_shift, w_piso_clr, w_done;
    logic [IW-1:0] w_out_idx;
    logic [1:0]    w_frame_cnt;

    piso_out_ctrl #(.NUM_TAPS(N), .IDX_W(IW), .FCNT_W(16)) u_dut (
        .CLKEXT(clk), .CLR_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .ABORT(abort), .OUT_READY(out_ready), .OUT_VALID(out_valid),
        .OUT_LAST(out_last), .OUT_IDX(out_idx), .PISO_EN(piso_en),
        .PISO_SHIFT(piso_shift), .PISO_CLR(piso_clr), .DONE(done),
        .FRAME_CNT(frame_cnt)
    );

    piso_out_ctrl #(.NUM_TAPS(N), .IDX_W(IW), .FCNT_W(2)) u_wrap (
        .CLKEXT(clk), .CLR_N(rst_n), .IN_VALID(in_valid), .IN_READY(w_in_ready),
        .ABORT(abort), .OUT_READY(out_ready), .OUT_VALID(w_out_valid),
        .OUT_LAST(w_out_last), .OUT_IDX(w_out_idx), .PISO_EN(w_piso_en),
        .PISO_SHIFT(w_piso_shift), .PISO_CLR(w_piso_clr), .DONE(w_done),
        .FRAME_CNT(w_frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // pos: -1 idle, 0 load cycle, 1..N presenting word pos-1, N+1 done cycle
    int         pos = -1;
    int         cnt = 0;
    bit         chk_en = 1'b0;
    logic [7:0] din   [N];
    logic [7:0] frame [N];
    logic [7:0] piso  [N];
    logic       l_en = 1'b0, l_sh = 1'b0, l_clr = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pos <= -1;
            cnt <= 0;
        end else if (abort) begin
            pos <= -1;
        end else if (pos == -1) begin
            if (in_valid) begin
                pos   <= 0;
                frame <= din;
            end
        end else if (pos == 0) begin
            pos <= 1;
        end else if (pos <= N) begin
            if (out_ready) pos <= pos + 1;
        end else begin
            pos <= -1;
            cnt <= cnt + 1;
        end
    end

    // Behavioural PISO following the DUT controls sampled at the prior negedge.
    always @(posedge clk) begin
        if (l_clr) begin
            for (int i = 0; i < N; i++) piso[i] <= 8'h00;
        end else if (l_en && !l_sh) begin
            piso <= din;
        end else if (l_en && l_sh) begin
            for (int i = 0; i < N - 1; i++) piso[i] <= piso[i+1];
            piso[N-1] <= 8'h00;
        end
    end

    bit e_rdy, e_vld, e_last, e_en, e_sh, e_clr, e_done;
    int e_idx;

    always @(negedge clk) begin
        l_en  <= piso_en;
        l_sh  <= piso_shift;
        l_clr <= piso_clr;
        if (chk_en) begin
            e_rdy = 0; e_vld = 0; e_last = 0; e_en = 0; e_sh = 0; e_clr = 0; e_done = 0; e_idx = 0;
            if (!rst_n || abort) begin
                e_clr = 1;
            end else begin
                e_rdy  = (pos == -1);
                e_vld  = (pos >= 1 && pos <= N);
                if (e_vld) begin
                    e_idx  = pos - 1;
                    e_last = (pos == N);
                end
                e_sh   = e_vld && out_ready && (pos < N);
                e_en   = (pos == 0) || e_sh;
                e_done = (pos == N + 1);
                e_clr  = e_done;
            end
            chk("in_ready",   in_ready,   e_rdy);
            chk("out_valid",  out_valid,  e_vld);
            chk("out_last",   out_last,   e_last);
            chk("out_idx",    out_idx,    e_idx);
            chk("piso_en",    piso_en,    e_en);
            chk("piso_shift", piso_shift, e_sh);
            chk("piso_clr",   piso_clr,   e_clr);
            chk("done",       done,       e_done);
            chk("frame_cnt",  frame_cnt,  cnt & 32'hFFFF);
            chk("wrap_ctrl",
                {w_in_ready, w_out_valid, w_out_last, w_out_idx, w_piso_en, w_piso_shift, w_piso_clr, w_done},
                {e_rdy, e_vld, e_last, e_idx[IW-1:0], e_en, e_sh, e_clr, e_done});
            chk("wrap_cnt",   w_frame_cnt, cnt & 3);
            if (e_vld && out_ready) chk("word", piso[0], frame[e_idx]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic start_frame(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        din[0] = a; din[1] = b; din[2] = c; din[3] = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    logic [7:0] nom  [N];
    logic [1:0] wexp [5];

    initial begin
        nom[0] = 8'hAA; nom[1] = 8'hBB; nom[2] = 8'hCC; nom[3] = 8'hDD;
        wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;
        for (int i = 0; i < N; i++) din[i] = 8'h00;

        // Reset for two cycles
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_clr", piso_clr, 1'b1);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", frame_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", in_ready, 1'b1);

        // Nominal frame
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        din = nom;
        @(negedge clk);
        chk("nom_accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("nom_load_en", piso_en, 1'b1);
        chk("nom_load_shift", piso_shift, 1'b0);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("nom_idx", out_idx, k);
            chk("nom_last", out_last, (k == N - 1));
            chk("nom_shift", piso_shift, (k < N - 1));
            chk("nom_word", piso[0], nom[k]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("nom_done", done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nom_cnt", frame_cnt, 16'd1);
        chk("nom_ready_back", in_ready, 1'b1);
        chk("nom_done_drop", done, 1'b0);

        // Backpressure at idx 1
        start_frame(8'h11, 8'h22, 8'h33, 8'h44);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_idx", out_idx, 1);
            chk("bp_en", piso_en, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_cnt", frame_cnt, 16'd2);

        // Abort at idx 2
        start_frame(8'h51, 8'h52, 8'h53, 8'h54);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("ab_valid", out_valid, 1'b0);
        chk("ab_clr", piso_clr, 1'b1);
        chk("ab_en", piso_en, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("ab_idle_ready", in_ready, 1'b1);
        chk("ab_idle_valid", out_valid, 1'b0);
        chk("ab_nodone", done, 1'b0);
        chk("ab_cnt", frame_cnt, 16'd2);
        start_frame(8'h61, 8'h62, 8'h63, 8'h64);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ab_restart_idx", out_idx, 0);
        chk("ab_restart_word", piso[0], 8'h61);
        wait_done("ab_next_done");
        chk("ab_next_cnt", frame_cnt, 16'd3);

        // ABORT beats IN_VALID in IDLE
        @(posedge clk); #1;
        abort = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("pri_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("pri_noload", piso_en, 1'b0);
        chk("pri_idle", in_ready, 1'b1);

        // Mid-frame reset
        start_frame(8'h71, 8'h72, 8'h73, 8'h74);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_clr", piso_clr, 1'b1);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_cnt", frame_cnt, 16'd0);
        chk("mrst_ready_back", in_ready, 1'b1);

        // Wrap on the FCNT_W=2 instance
        for (int f = 0; f < 5; f++) begin
            start_frame(8'h80 + 8'(f), 8'h90, 8'hA0, 8'hB0);
            wait_done("wrap_done");
            chk("wrap_seq", w_frame_cnt, wexp[f]);
            chk("wrap_main", frame_cnt, f + 1);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 299) != 0);
            abort     = ($urandom_range(0, 99) < 4);
            out_ready = ($urandom_range(0, 99) < 70);
            if (pos == -1) begin
                if (!in_valid && $urandom_range(0, 1) == 1) begin
                    in_valid = 1'b1;
                    for (int k = 0; k < N; k++) din[k] = 8'($urandom);
                end
            end else begin
                // IN_VALID outside IDLE must be ignored; DATA_IN stays put.
                in_valid = ($urandom_range(0, 9) == 0);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/piso_out_ctrl.md
Name: piso_out_ctrl

Overview:
- Sequencer for the output-side parallel-in/serial-out buffer (PISO, WIDTH x NUM_TAPS).
- Accepts one parallel result vector per frame from the NPU output stage via valid/ready.
- Drives the PISO load, shift, enable and clear controls, then streams the words downstream one per handshake with a tap index and last flag.
- Sits between the classifier output registers and the serial output port.

Parameters:
- NUM_TAPS, 4, words per frame (≥2).
- IDX_W, 2, tap index width, ≥ clog2(NUM_TAPS).
- FCNT_W, 16, completed-frame counter width.

Ports:
- CLKEXT  in  1  system clock, rising edge.
- CLR_N  in  1  synchronous active-low reset.
- IN_VALID  in  1  parallel frame available on the PISO DATA_IN bus.
- IN_READY  out  1  controller can accept a frame.
- ABORT  in  1  synchronous frame abort.
- OUT_READY  in  1  downstream accepts the current word.
- OUT_VALID  out  1  PISO DATA_OUT holds a valid word.
- OUT_LAST  out  1  current word is tap NUM_TAPS-1.
- OUT_IDX  out  IDX_W  index of the current word (0 first).
- PISO_EN  out  1  to PISO EN_PISO_OUT.
- PISO_SHIFT  out  1  to PISO SHIFT_OUT.
- PISO_CLR  out  1  to PISO CLR_PISO_OUT (active high).
- DONE  out  1  one-cycle pulse when a frame completes.
- FRAME_CNT  out  FCNT_W  completed frames, wraps.

Behaviour:
- Interface: one clock, CLKEXT. Reset CLR_N is synchronous and active-low.
- PISO contract:
  - EN=1, SHIFT=0: parallel load; DATA_OUT then presents word 0.
  - EN=1, SHIFT=1: advance one word.
  - EN=0: hold.
  - CLR: zero the buffer.
- FSM states: IDLE, LOAD, STREAM, DONE_ST. All state is registered. Controls are decoded from state plus the gating inputs below.
- Reset (CLR_N=0 at an edge):
  - Next-state values: state=IDLE, idx=0, FRAME_CNT=0.
  - PISO_CLR=1 combinationally while CLR_N=0.
  - IN_READY=0 while CLR_N=0.
  - All other outputs 0 after the edge. IN_READY=1 from the first cycle after release.
- IDLE:
  - IN_READY = !ABORT.
  - On IN_VALID & IN_READY, go to LOAD.
- LOAD (exactly 1 cycle):
  - PISO_EN=1, PISO_SHIFT=0, idx=0.
  - Next state STREAM.
- STREAM:
  - OUT_VALID=1, OUT_IDX=idx, OUT_LAST=(idx==NUM_TAPS-1).
  - On OUT_READY with idx<NUM_TAPS-1: PISO_EN=1 and PISO_SHIFT=1 in the same cycle (Mealy on OUT_READY); idx increments.
  - OUT_READY=0: PISO_EN=0; word and idx hold (stall of any length).
  - On OUT_READY with OUT_LAST: no shift; go to DONE_ST.
- DONE_ST (1 cycle):
  - DONE=1 and PISO_CLR=1.
  - FRAME_CNT increments, wrapping at 2^FCNT_W.
  - Next state IDLE.
- Latency:
  - Accept edge to first OUT_VALID: 2 cycles.
  - Minimum frame period with OUT_READY held high: NUM_TAPS+3 cycles.
- ABORT=1, any state, overrides all other inputs:
  - PISO_CLR=1 and PISO_EN=0 that cycle.
  - Next state IDLE, idx=0, no DONE, FRAME_CNT unchanged.
  - Handshakes are suppressed that cycle: IN_READY=0, and OUT_VALID is forced 0 so no word is transferred.
- Simultaneous events: CLR_N=0 beats ABORT, which beats IN_VALID and OUT_READY.
- IN_VALID outside IDLE is ignored; the source must hold DATA_IN stable until the handshake completes.
- No combinational path from OUT_READY to OUT_VALID or IN_READY.

Test Plan:
- Reset: CLR_N=0 for 2 cycles → PISO_CLR=1, IN_READY=0, OUT_VALID=0, FRAME_CNT=0. After release, IN_READY=1.
- Nominal frame, NUM_TAPS=4, DATA_IN={AA,BB,CC,DD}, OUT_READY=1:
  - LOAD at accept+1.
  - OUT_IDX 0,1,2,3 on four consecutive cycles; OUT_LAST only at idx 3.
  - 3 shift pulses, then DONE=1 and FRAME_CNT=1.
  - IN_READY back high at accept+7.
- Backpressure: OUT_READY low 3 cycles at idx 1 → OUT_IDX stays 1 and PISO_EN=0 during the stall; the stream resumes with no dropped or duplicated index.
- Abort: assert ABORT at idx 2 → next cycle IDLE, OUT_VALID=0, PISO_CLR pulsed, DONE=0, FRAME_CNT unchanged. The next frame streams normally from idx 0.
- Priority: ABORT with IN_VALID in IDLE → no LOAD. Mid-frame reset → state returns to IDLE and FRAME_CNT=0.
- Wrap: FCNT_W=2, run 5 frames → FRAME_CNT sequence 1,2,3,0,1.
